// File: rtl/fp_add_align.sv
// FP32 add/sub front-end: unpacks, orders by magnitude, aligns the smaller mantissa one bit
// per cycle with sticky tracking, then adds/subtracts; latency cnt+2; one op in flight, holds result until out_ready.
module fp_add_align #(
    parameter int EXP_W     = 8,
    parameter int FRAC_W    = 23,
    parameter int MAX_SHIFT = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [EXP_W-1:0]        out_exp,
    output logic [FRAC_W+1:0]       out_mant,
    output logic                    out_sticky,
    output logic                    out_special
);
    localparam int MW = FRAC_W + 1;
    localparam int SW = EXP_W + FRAC_W;
    localparam int CW = $clog2(MAX_SHIFT + 1);
    localparam logic [CW-1:0] CNT_CAP   = CW'(MAX_SHIFT);
    localparam logic [MW:0]   QNAN_MANT = (MW+1)'(1) << (FRAC_W - 1);

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [MW-1:0]      mant_l, mant_s;
    logic [EXP_W-1:0]   exp_l;
    logic               sign_l, effsub, sticky, special, nan_res, inf_sign;

    logic [EXP_W-1:0]   ea, eb, ea_eff, eb_eff, diff;
    logic [MW-1:0]      ma, mb;
    logic               sa, sb, effsub_in, a_larger, a_nan, b_nan, a_inf, b_inf, any_special;
    logic [MW:0]        sum;

    // Denormals carry no hidden bit but share the exponent of the smallest normal.
    assign ea          = a[SW-1:FRAC_W];
    assign eb          = b[SW-1:FRAC_W];
    assign ma          = {|ea, a[FRAC_W-1:0]};
    assign mb          = {|eb, b[FRAC_W-1:0]};
    assign ea_eff      = (ea == '0) ? EXP_W'(1) : ea;
    assign eb_eff      = (eb == '0) ? EXP_W'(1) : eb;
    assign sa          = a[SW];
    assign sb          = b[SW] ^ sub;
    assign effsub_in   = sa ^ sb;
    assign a_larger    = (ea_eff > eb_eff) || ((ea_eff == eb_eff) && (ma >= mb));
    assign diff        = a_larger ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
    assign a_nan       = (&ea) && (|a[FRAC_W-1:0]);
    assign b_nan       = (&eb) && (|b[FRAC_W-1:0]);
    assign a_inf       = (&ea) && !(|a[FRAC_W-1:0]);
    assign b_inf       = (&eb) && !(|b[FRAC_W-1:0]);
    assign any_special = (&ea) || (&eb);

    assign sum      = effsub ? ({1'b0, mant_l} - {1'b0, mant_s}) : ({1'b0, mant_l} + {1'b0, mant_s});
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mant_l      <= '0;
            mant_s      <= '0;
            exp_l       <= '0;
            sign_l      <= 1'b0;
            effsub      <= 1'b0;
            sticky      <= 1'b0;
            special     <= 1'b0;
            nan_res     <= 1'b0;
            inf_sign    <= 1'b0;
            out_valid   <= 1'b0;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_mant    <= '0;
            out_sticky  <= 1'b0;
            out_special <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    exp_l    <= a_larger ? ea_eff : eb_eff;
                    mant_l   <= a_larger ? ma : mb;
                    mant_s   <= a_larger ? mb : ma;
                    sign_l   <= a_larger ? sa : sb;
                    effsub   <= effsub_in;
                    sticky   <= 1'b0;
                    special  <= any_special;
                    nan_res  <= a_nan || b_nan || (a_inf && b_inf && effsub_in);
                    inf_sign <= a_inf ? sa : sb;
                    // Specials take the zero-shift path so their latency matches cnt=0.
                    if (any_special)
                        cnt <= '0;
                    else if (diff >= EXP_W'(MAX_SHIFT))
                        cnt <= CNT_CAP;
                    else
                        cnt <= diff[CW-1:0];
                    state <= ALIGN;
                end
                ALIGN: begin
                    if (cnt == '0) begin
                        state <= ADD;
                    end else if (cnt == CNT_CAP) begin
                        sticky <= sticky | (|mant_s);
                        mant_s <= '0;
                        cnt    <= cnt - 1'b1;
                    end else begin
                        sticky <= sticky | mant_s[0];
                        mant_s <= mant_s >> 1;
                        cnt    <= cnt - 1'b1;
                    end
                end
                ADD: begin
                    out_valid   <= 1'b1;
                    out_sticky  <= sticky;
                    out_special <= special;
                    if (special) begin
                        out_exp  <= '1;
                        out_mant <= nan_res ? QNAN_MANT : '0;
                        out_sign <= nan_res ? sign_l : inf_sign;
                    end else begin
                        out_exp  <= exp_l;
                        out_mant <= sum;
                        out_sign <= (effsub && (sum == '0)) ? 1'b0 : sign_l;
                    end
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_align.sv
// Bench for fp_add_align: directed cases, backpressure, mid-operation reset and random ops
// compared against an arithmetic reference model.
module tb_fp_add_align;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b;
    logic        out_sign, out_sticky, out_special;
    logic [7:0]  out_exp;
    logic [24:0] out_mant;

    int n_assert = 0;
    int n_fail   = 0;

    fp_add_align dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_sticky(out_sticky), .out_special(out_special)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: exact shift with sticky as "any discarded bit set", then plain integer add/sub.
    task automatic model(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         output logic es, output logic [7:0] ee, output logic [24:0] em,
                         output logic est, output logic esp, output int elat);
        int     xa, xb, fa, fb, da, db, sh;
        longint ma, mb, ml, ms, res;
        logic   sa, sb, effs, a_big, nan_a, nan_b, inf_a, inf_b;
        xa = int'(ia[30:23]); xb = int'(ib[30:23]);
        fa = int'(ia[22:0]);  fb = int'(ib[22:0]);
        ma = (xa != 0 ? 64'd8388608 : 64'd0) + longint'(fa);
        mb = (xb != 0 ? 64'd8388608 : 64'd0) + longint'(fb);
        da = (xa == 0) ? 1 : xa;
        db = (xb == 0) ? 1 : xb;
        sa = ia[31]; sb = ib[31] ^ isub; effs = sa ^ sb;
        a_big = (da > db) || (da == db && ma >= mb);
        nan_a = (xa == 255) && (fa != 0); nan_b = (xb == 255) && (fb != 0);
        inf_a = (xa == 255) && (fa == 0); inf_b = (xb == 255) && (fb == 0);
        est = 1'b0;
        if (xa == 255 || xb == 255) begin
            esp = 1'b1; ee = 8'hFF; elat = 2;
            if (nan_a || nan_b || (inf_a && inf_b && effs)) begin
                em = 25'h0400000; es = a_big ? sa : sb;
            end else begin
                em = 25'h0; es = inf_a ? sa : sb;
            end
        end else begin
            esp = 1'b0;
            ml = a_big ? ma : mb;
            ms = a_big ? mb : ma;
            sh = a_big ? da - db : db - da;
            if (sh > 26) sh = 26;
            est = ((ms & ((64'd1 << sh) - 1)) != 0);
            res = effs ? ml - (ms >> sh) : ml + (ms >> sh);
            em = res[24:0];
            ee = 8'(a_big ? da : db);
            es = (effs && res == 0) ? 1'b0 : (a_big ? sa : sb);
            elat = sh + 2;
        end
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                          input bit hold, input string tag);
        logic        es, est, esp;
        logic [7:0]  ee;
        logic [24:0] em;
        logic [63:0] snap;
        int          elat, lat, w;
        model(ia, ib, isub, es, ee, em, est, esp, elat);
        @(negedge clk);
        out_ready = !hold;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_sign"},    32'(out_sign), 32'(es));
        chk({tag, "_exp"},     32'(out_exp), 32'(ee));
        chk({tag, "_mant"},    32'(out_mant), 32'(em));
        chk({tag, "_sticky"},  32'(out_sticky), 32'(est));
        chk({tag, "_special"}, 32'(out_special), 32'(esp));
        if (hold) begin
            snap = {29'd0, out_sign, out_exp, out_mant, out_sticky};
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); @(negedge clk);
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_busy"},  32'(in_ready), 32'd0);
                chk({tag, "_hold_data"},  32'({out_sign, out_exp, out_mant, out_sticky} != snap[35:0]), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          xa, xb, r, stale;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_outputs",  32'({out_sign, out_exp, out_mant, out_sticky, out_special} != 0), 32'd0);

        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, "one_plus_one");
        run_op(32'h3F800000, 32'h3F000000, 1'b0, 1'b0, "one_plus_half");
        run_op(32'h3F000000, 32'h3F800000, 1'b1, 1'b0, "swap_sub");
        run_op(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, "exact_zero");
        run_op(32'h3F800000, 32'h30800000, 1'b0, 1'b0, "shift_cap");
        run_op(32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, "nan_in");
        run_op(32'h7F800000, 32'h7F800000, 1'b1, 1'b0, "inf_minus_inf");
        run_op(32'h3F800000, 32'hFF800000, 1'b0, 1'b0, "neg_inf");
        run_op(32'h00000003, 32'h00000001, 1'b1, 1'b0, "denormals");
        run_op(32'h40400000, 32'h3F800000, 1'b1, 1'b1, "backpressure");

        // Reset during a long alignment must abort it with no result.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h30800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid",    32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        chk("abort_no_stale", 32'(stale), 32'd0);
        run_op(32'h3F800000, 32'h3F000000, 1'b0, 1'b0, "after_abort");

        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 15));
            xa = int'($urandom_range(0, 254));
            xb = xa + int'($urandom_range(0, 60)) - 30;
            if (xb < 0) xb = 0;
            if (xb > 254) xb = 254;
            if (r == 0) xa = 255;
            if (r == 1) xb = 255;
            ra = {1'($urandom_range(0, 1)), 8'(xa), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'(xb), 23'($urandom)};
            if (r < 2 && $urandom_range(0, 1) == 1) begin ra[22:0] = '0; rb[22:0] = '0; end
            if (r == 2) rb = ra;
            if (r == 3) rb = {~ra[31], ra[30:0]};
            run_op(ra, rb, 1'($urandom_range(0, 1)), (r == 4), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
